// File: rtl/seq_mul_div.sv
// Iterative unsigned multiply/divide unit: one result bit per clock, double-width
// result split into hi/lo words, with a single-cycle done pulse.
module seq_mul_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH:0]     mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic                 div_ge_s;
  logic [WIDTH:0]       div_rem_s;
  logic [2*WIDTH:0]     div_next_s;
  logic [2*WIDTH:0]     acc_step_s;

  // One iteration of either algorithm. Multiply keeps the product in the upper
  // half and the remaining multiplier bits in the lower half; divide keeps the
  // remainder in bits [2W:W] and the dividend/quotient shift register in [W-1:0].
  always_comb begin
    if (acc_q[0]) begin
      mul_sum_s = acc_q[2*WIDTH:WIDTH] + {1'b0, a_q};
    end else begin
      mul_sum_s = acc_q[2*WIDTH:WIDTH];
    end
    mul_next_s  = {1'b0, mul_sum_s, acc_q[WIDTH-1:1]};

    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_q});
    if (div_ge_s) begin
      div_rem_s = div_shift_s - {1'b0, b_q};
    end else begin
      div_rem_s = div_shift_s;
    end
    div_next_s  = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};

    if (op_q) begin
      acc_step_s = div_next_s;
    end else begin
      acc_step_s = mul_next_s;
    end
  end

  // Next-state and output decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_RUN;
          if (op) begin
            acc_d = {{(WIDTH + 1){1'b0}}, a};
          end else begin
            acc_d = {{(WIDTH + 1){1'b0}}, b};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_hi_d = acc_step_s[2*WIDTH-1:WIDTH];
          res_lo_d = acc_step_s[WIDTH-1:0];
          dbz_d    = op_q & (b_q == {WIDTH{1'b0}});
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {(2 * WIDTH + 1){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div: stimulus pushes expected results, a negedge
// monitor pops them on done and also checks latency, busy length and result hold.
module tb_seq_mul_div;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cycle_cnt = 0;
  int           busy_len = 0;
  logic         rst_prev = 1'b0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;
  logic         held_dbz = 1'b0;

  seq_mul_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Edge counter and the reset value the DUT saw at the latest edge.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    rst_prev  <= reset;
  end

  // Monitor: reset state, busy run length, done results/latency, result hold.
  always @(negedge clk) begin
    if (!rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", result_hi, 0);
      chk("rst_lo", result_lo, 0);
      chk("rst_dbz", div_by_zero, 0);
      held_hi  = '0;
      held_lo  = '0;
      held_dbz = 1'b0;
      busy_len = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        chk("busy_len", busy_len, 16);
        busy_len = 0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cycle_cnt);
        end else begin
          e = sb_q.pop_front();
          chk("result_hi", result_hi, e.hi);
          chk("result_lo", result_lo, e.lo);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("done_cycle", cycle_cnt, e.due);
        end
        held_hi  = result_hi;
        held_lo  = result_lo;
        held_dbz = div_by_zero;
      end else begin
        chk("hold_hi", result_hi, held_hi);
        chk("hold_lo", result_lo, held_lo);
        chk("hold_dbz", div_by_zero, held_dbz);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic run_op(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    op    = opv;
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    sb_q.push_back('{hi: hi, lo: lo, dbz: dbz, due: cycle_cnt + W});
    start = 1'b0;
    op    = ~opv;
    a     = ~av;
    b     = ~bv;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k0;
    // Reset held with start high, then release idle.
    reset = 1'b0;
    start = 1'b1;
    a     = 16'h0003;
    b     = 16'h0004;
    step();
    step();
    reset = 1'b1;
    start = 1'b0;
    repeat (4) step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Multiply and divide directed vectors.
    run_op(1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    run_op(1'b0, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    run_op(1'b1, 16'd1000, 16'd7, 16'd6, 16'd142, 1'b0);
    run_op(1'b1, 16'd5, 16'd9, 16'd5, 16'd0, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);

    // Starts during RUN (k+3) and at the DONE-entering edge (k+16) are ignored.
    op    = 1'b0;
    a     = 16'h1234;
    b     = 16'h0010;
    start = 1'b1;
    step();
    sb_q.push_back('{hi: 16'h0001, lo: 16'h2340, dbz: 1'b0, due: cycle_cnt + W});
    start = 1'b0;
    step();
    step();
    op    = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    op    = 1'b0;
    a     = 16'h0003;
    b     = 16'h0005;
    start = 1'b1;
    step();
    start = 1'b0;
    drain();
    repeat (20) step();

    // start held high: accepts every 18 cycles.
    start = 1'b1;
    k0 = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin op = 1'b1; a = 16'hFFFF; b = 16'h0010; end
        1: begin op = 1'b0; a = 16'h8000; b = 16'h0002; end
        default: begin op = 1'b1; a = 16'd100; b = 16'd10; end
      endcase
      step();
      if (i == 0) k0 = cycle_cnt;
      case (i)
        0: sb_q.push_back('{hi: 16'h000F, lo: 16'h0FFF, dbz: 1'b0, due: k0 + 16});
        1: sb_q.push_back('{hi: 16'h0001, lo: 16'h0000, dbz: 1'b0, due: k0 + 18 + 16});
        default: sb_q.push_back('{hi: 16'd0, lo: 16'd10, dbz: 1'b0, due: k0 + 36 + 16});
      endcase
      if (i < 2) repeat (17) step();
    end
    start = 1'b0;
    drain();

    // Reset at edge k+8 of a multiply aborts it; then a fresh op completes.
    op    = 1'b0;
    a     = 16'h00FF;
    b     = 16'h0101;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("abort_busy", busy, 0);
    chk("abort_lo", result_lo, 0);
    run_op(1'b0, 16'd300, 16'd300, 16'h0001, 16'h5F90, 1'b0);

    repeat (5) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
